// File: rtl/cond_branch_unit_if.sv
// Branch request / branch resolution bundle between the decode->execute
// slot and the conditional branch unit. The unit itself is the slave.
interface cond_branch_unit_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  valid_in;
    logic [3:0]            cond_in;
    logic [ADDR_WIDTH-1:0] target_in;
    logic                  branch_taken;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic                  flush;
    logic                  busy;

    modport master (
        output valid_in, cond_in, target_in,
        input  branch_taken, branch_target, flush, busy
    );

    modport slave (
        input  valid_in, cond_in, target_in,
        output branch_taken, branch_target, flush, busy
    );
endinterface

// File: rtl/cond_branch_unit.sv
// Conditional branch unit for the 8-bit pipelined CPU.
// Aligns the early zero flag with the registered flags, resolves the carry
// source, evaluates the 4-bit condition code of the branch in stage 1 and
// issues a registered taken pulse plus target, followed by a fixed-length
// flush of the younger pipeline stages.
// Optional build macro COND_STATS_EN adds eval_count / taken_count outputs.
module cond_branch_unit #(
    parameter int ADDR_WIDTH  = 16,
    parameter int FLUSH_SLOTS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    cond_branch_unit_if.slave    br,
    input  logic                 arithCarry,
    input  logic                 logicCarry,
    input  logic                 zero,
    input  logic                 sign,
    input  logic                 overflow,
    input  logic [1:0]           CarrySelectDelayed,
    output logic                 carry
`ifdef COND_STATS_EN
    ,
    output logic [15:0]          eval_count,
    output logic [15:0]          taken_count
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                state, stateNext;
    logic [2:0]            cnt, cntNext;
    logic                  takeNow;
    logic                  evalNow;

    logic                  zero_p1;
    logic                  valid_p1;
    logic [3:0]            cond_p1;
    logic [ADDR_WIDTH-1:0] target_p1;

    logic                  taken_p2;
    logic [ADDR_WIDTH-1:0] target_p2;

    // Condition-code truth table on the aligned flags.
    function automatic logic condTrue(input logic [3:0] cc, input logic c,
                                      input logic z, input logic s,
                                      input logic v);
        logic r;
        case (cc)
            4'd0:    r = 1'b1;
            4'd1:    r = z;
            4'd2:    r = ~z;
            4'd3:    r = c;
            4'd4:    r = ~c;
            4'd5:    r = s;
            4'd6:    r = ~s;
            4'd7:    r = v;
            4'd8:    r = ~v;
            4'd9:    r = c & ~z;
            4'd10:   r = ~c | z;
            4'd11:   r = (s == v);
            4'd12:   r = (s != v);
            4'd13:   r = ~z & (s == v);
            4'd14:   r = z | (s != v);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Carry source mux; purely combinational so a select change is seen at once.
    always_comb begin
        carry = 1'b0;
        case (CarrySelectDelayed)
            2'b00:   carry = arithCarry;
            2'b01:   carry = logicCarry;
            2'b10:   carry = 1'b0;
            default: carry = 1'b1;
        endcase
    end

    // Next-state logic: resolve the stage-1 branch in IDLE, count down in FLUSH.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        takeNow   = 1'b0;
        evalNow   = 1'b0;
        case (state)
            IDLE: begin
                evalNow = valid_p1;
                if (valid_p1 && condTrue(cond_p1, carry, zero_p1, sign, overflow)) begin
                    takeNow   = 1'b1;
                    stateNext = FLUSH;
                    cntNext   = 3'(FLUSH_SLOTS - 1);
                end
            end
            FLUSH: begin
                if (cnt == 3'd0) begin
                    stateNext = IDLE;
                end else begin
                    cntNext = cnt - 3'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // FSM state and flush slot counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else if (!stall) begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // ---- stage 0 -> 1: zero alignment and branch capture (control) ----
    // A taken branch or an active flush squashes whatever valid_in shows.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            zero_p1  <= 1'b0;
            valid_p1 <= 1'b0;
        end else if (!stall) begin
            zero_p1  <= zero;
            valid_p1 <= (state == IDLE) && !takeNow && br.valid_in;
        end
    end

    // Stage-1 condition code and target payload; no reset needed on data.
    always_ff @(posedge clk) begin
        if (!stall && state == IDLE) begin
            cond_p1   <= br.cond_in;
            target_p1 <= br.target_in;
        end
    end

    // ---- stage 1 -> 2: registered taken pulse and its target ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            taken_p2  <= 1'b0;
            target_p2 <= '0;
        end else if (!stall) begin
            taken_p2 <= takeNow;
            if (takeNow) begin
                target_p2 <= target_p1;
            end
        end
    end

    assign br.branch_taken  = taken_p2;
    assign br.branch_target = target_p2;
    assign br.flush         = (state == FLUSH);
    assign br.busy          = (state == FLUSH);

`ifdef COND_STATS_EN
    // Wrapping evaluation and taken statistics.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            eval_count  <= 16'd0;
            taken_count <= 16'd0;
        end else if (!stall) begin
            if (evalNow) begin
                eval_count <= eval_count + 16'd1;
            end
            if (takeNow) begin
                taken_count <= taken_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cond_branch_unit.sv
// Scoreboard bench for cond_branch_unit: stimulus pushes expected taken
// pulses (target, pulse length, flush length); a negedge monitor pops and
// compares whenever a branch_taken pulse appears.
module tb_cond_branch_unit;
    localparam int AW = 16;
    localparam int FS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, stall;
    logic       arithCarry, logicCarry, zero, sign, overflow, carry;
    logic [1:0] csd;

    cond_branch_unit_if #(.ADDR_WIDTH(AW)) bus ();

`ifdef COND_STATS_EN
    logic [15:0] evalCount, takenCount;
`endif

    cond_branch_unit #(.ADDR_WIDTH(AW), .FLUSH_SLOTS(FS)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .stall              (stall),
        .br                 (bus),
        .arithCarry         (arithCarry),
        .logicCarry         (logicCarry),
        .zero               (zero),
        .sign               (sign),
        .overflow           (overflow),
        .CarrySelectDelayed (csd),
        .carry              (carry)
`ifdef COND_STATS_EN
        ,
        .eval_count         (evalCount),
        .taken_count        (takenCount)
`endif
    );

    typedef struct {
        logic [15:0] tgt;
        int          pulseLen;
        int          flushLen;
    } exp_t;

    exp_t expQ[$];
    exp_t cur;
    int   compared   = 0;
    int   mismatched = 0;
    int   expEval    = 0;
    int   expTaken   = 0;

    // cond, zero before/after sample, sign, overflow, carry select,
    // arithCarry, logicCarry, expected carry, expected taken, target
    typedef struct packed {
        logic [3:0]  cond;
        logic        zb, za, s, v;
        logic [1:0]  csd;
        logic        ac, lc, ec, et;
        logic [15:0] tgt;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop an expectation on each rising branch_taken and measure
    // pulse and flush lengths.
    logic takenPrev = 1'b0, flushPrev = 1'b0;
    int   pulseCnt = 0, flushCnt = 0;
    always @(negedge clk) begin
        if (bus.branch_taken && !takenPrev) begin
            if (expQ.size() == 0) begin
                check("unexpected_pulse", {16'h0, bus.branch_target}, 32'hFFFF_FFFF);
                cur = '{16'h0, 0, 0};
            end else begin
                cur = expQ.pop_front();
                check("branch_target", {16'h0, bus.branch_target}, {16'h0, cur.tgt});
            end
            pulseCnt = 0;
        end
        if (bus.flush && !flushPrev) flushCnt = 0;
        if (bus.branch_taken) pulseCnt++;
        if (bus.flush) begin
            flushCnt++;
            check("busy_tracks_flush", {31'h0, bus.busy}, 32'd1);
        end
        if (!bus.branch_taken && takenPrev) check("pulse_len", pulseCnt, cur.pulseLen);
        if (!bus.flush && flushPrev) check("flush_len", flushCnt, cur.flushLen);
        takenPrev = bus.branch_taken;
        flushPrev = bus.flush;
    end

    initial begin
        vecs[0]  = '{4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234};
        vecs[1]  = '{4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1111};
        vecs[2]  = '{4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 16'h2222};
        vecs[3]  = '{4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h3333};
        vecs[4]  = '{4'd3,  1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4444};
        vecs[5]  = '{4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 16'h5555};
        vecs[6]  = '{4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 16'h6666};
        vecs[7]  = '{4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 16'h7777};
        vecs[8]  = '{4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 16'h8888};
        vecs[9]  = '{4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h9999};
        vecs[10] = '{4'd13, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 16'hAAAA};
        vecs[11] = '{4'd12, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBBBB};
        vecs[12] = '{4'd11, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 16'hCCCC};
        vecs[13] = '{4'd14, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 16'hDDDD};
        vecs[14] = '{4'd6,  1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 16'hEEEE};
        vecs[15] = '{4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0F0F};
        vecs[16] = '{4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1F1F};
        vecs[17] = '{4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2E2E};
        vecs[18] = '{4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2F2F};

        // Reset held together with stall and a pending branch.
        reset_n = 1'b0; stall = 1'b1;
        bus.valid_in = 1'b1; bus.cond_in = 4'd0; bus.target_in = 16'hDEAD;
        arithCarry = 1'b0; logicCarry = 1'b0; zero = 1'b0;
        sign = 1'b0; overflow = 1'b0; csd = 2'b10;
        repeat (3) step();
        check("rst_taken",  {31'h0, bus.branch_taken}, 32'd0);
        check("rst_target", {16'h0, bus.branch_target}, 32'd0);
        check("rst_flush",  {31'h0, bus.flush}, 32'd0);
        check("rst_busy",   {31'h0, bus.busy}, 32'd0);
`ifdef COND_STATS_EN
        check("rst_eval_count",  {16'h0, evalCount}, 32'd0);
        check("rst_taken_count", {16'h0, takenCount}, 32'd0);
`endif
        bus.valid_in = 1'b0; stall = 1'b0; reset_n = 1'b1;
        repeat (2) step();
        check("post_rst_taken", {31'h0, bus.branch_taken}, 32'd0);
        check("post_rst_flush", {31'h0, bus.flush}, 32'd0);

        // Directed condition / carry-select / alignment vectors.
        for (int i = 0; i < 19; i++) begin
            sign = vecs[i].s; overflow = vecs[i].v; csd = vecs[i].csd;
            arithCarry = vecs[i].ac; logicCarry = vecs[i].lc;
            zero = vecs[i].zb;
            bus.valid_in = 1'b1; bus.cond_in = vecs[i].cond; bus.target_in = vecs[i].tgt;
            #1;
            check($sformatf("carry_v%0d", i), {31'h0, carry}, {31'h0, vecs[i].ec});
            if (vecs[i].et) begin
                expQ.push_back('{vecs[i].tgt, 1, FS});
                expTaken++;
            end
            expEval++;
            step();
            bus.valid_in = 1'b0; zero = vecs[i].za;
            step();
            repeat (FS + 2) step();
        end
        zero = 1'b0; sign = 1'b0; overflow = 1'b0; csd = 2'b10;

        // valid_in held high across the whole flush: only the first is taken.
        expQ.push_back('{16'hA000, 1, FS});
        expEval++; expTaken++;
        bus.valid_in = 1'b1; bus.cond_in = 4'd0; bus.target_in = 16'hA000;
        step();
        bus.target_in = 16'hB000;
        repeat (FS + 1) step();
        bus.valid_in = 1'b0;
        repeat (FS + 2) step();

        // Back-to-back: not-taken then taken, evaluated in consecutive cycles.
        expQ.push_back('{16'hD00D, 1, FS});
        expEval += 2; expTaken++;
        bus.valid_in = 1'b1; bus.cond_in = 4'd15; bus.target_in = 16'hC00C;
        step();
        bus.cond_in = 4'd0; bus.target_in = 16'hD00D;
        step();
        bus.valid_in = 1'b0;
        repeat (FS + 3) step();

        // Stall for 3 cycles on the first flush cycle.
        expQ.push_back('{16'hE000, 4, FS + 3});
        expEval++; expTaken++;
        bus.valid_in = 1'b1; bus.cond_in = 4'd0; bus.target_in = 16'hE000;
        step();
        bus.valid_in = 1'b0;
        step();
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        repeat (FS + 2) step();

        // Reset asserted during the flush aborts it on the next edge.
        expQ.push_back('{16'hF000, 1, 1});
        bus.valid_in = 1'b1; bus.cond_in = 4'd0; bus.target_in = 16'hF000;
        step();
        bus.valid_in = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        check("rst_mid_flush_flush", {31'h0, bus.flush}, 32'd0);
        check("rst_mid_flush_busy",  {31'h0, bus.busy}, 32'd0);
        check("rst_mid_flush_taken", {31'h0, bus.branch_taken}, 32'd0);
        reset_n = 1'b1;
        expEval = 0; expTaken = 0;
        step();

        // Branch after reset: GT taken, then never.
        sign = 1'b1; overflow = 1'b1; zero = 1'b0;
        expQ.push_back('{16'h1357, 1, FS});
        expEval += 2; expTaken++;
        bus.valid_in = 1'b1; bus.cond_in = 4'd13; bus.target_in = 16'h1357;
        step();
        bus.valid_in = 1'b0;
        repeat (FS + 3) step();
        bus.valid_in = 1'b1; bus.cond_in = 4'd15; bus.target_in = 16'h2468;
        step();
        bus.valid_in = 1'b0;
        repeat (FS + 3) step();

        check("queue_drained", expQ.size(), 32'd0);
`ifdef COND_STATS_EN
        check("eval_count",  {16'h0, evalCount}, expEval);
        check("taken_count", {16'h0, takenCount}, expTaken);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
